// File: rtl/bht_update_queue.sv
// bht_update_queue
//
// Buffers resolved conditional-branch outcomes from EX and drains them, one
// per cycle, into the BHT write port. It also repairs the history of back-to-back
// updates to the same PC. Without this, the second write would shift stale
// history and lose the first write's outcome.
//
// Ports
//   clk, rstn        clock and asynchronous active-low reset
//   stall            BHT write port busy; the head entry is held
//   flush            drop every queued, not-yet-written entry
//   in_valid/ready   push handshake from EX
//   in_pc/taken/bh   resolved branch PC, real outcome and predict-time history
//   pc_update        BHT update PC (head entry)
//   outcome_real     BHT update outcome (head entry)
//   bh_ex            history the BHT shifts (repaired against the last write)
//   update_en        BHT write enable
//   count            occupied entries
//
// Configuration
//   BHT_UPD_BYPASS_EN: when the queue is empty and a push arrives with no stall
//   and no flush, the input is written through in the same cycle (0-cycle
//   latency). When this macro is undefined, the outputs depend on registered
//   state and stall only.

module bht_update_queue #(
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned bh_width   = 14,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_pc,
  input  logic                    in_taken,
  input  logic [bh_width-1:0]     in_bh,
  output logic [ADDR_WIDTH-1:0]   pc_update,
  output logic                    outcome_real,
  output logic [bh_width-1:0]     bh_ex,
  output logic                    update_en,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Queue storage (not reset)
  logic [ADDR_WIDTH-1:0] r_pc_mem    [DEPTH];
  logic                  r_taken_mem [DEPTH];
  logic [bh_width-1:0]   r_bh_mem    [DEPTH];

  logic [PtrW-1:0]       r_rd_ptr;
  logic [PtrW-1:0]       r_wr_ptr;
  logic [CntW-1:0]       r_count;

  // Last completed BHT write
  logic                  r_last_valid;
  logic [ADDR_WIDTH-1:0] r_last_pc;
  logic [bh_width-1:0]   r_last_hist;

  logic                  w_not_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_bypass;
  logic [ADDR_WIDTH-1:0] w_sel_pc;
  logic                  w_sel_taken;
  logic [bh_width-1:0]   w_sel_bh;
  logic                  w_repair;

  assign w_not_empty = (r_count != '0);
  assign in_ready    = (r_count != CntW'(DEPTH));
  assign w_pop       = w_not_empty & ~stall;

`ifdef BHT_UPD_BYPASS_EN
  assign w_bypass    = ~w_not_empty & in_valid & ~stall & ~flush;
  assign w_sel_pc    = w_bypass ? in_pc    : r_pc_mem[r_rd_ptr];
  assign w_sel_taken = w_bypass ? in_taken : r_taken_mem[r_rd_ptr];
  assign w_sel_bh    = w_bypass ? in_bh    : r_bh_mem[r_rd_ptr];
`else
  assign w_bypass    = 1'b0;
  assign w_sel_pc    = r_pc_mem[r_rd_ptr];
  assign w_sel_taken = r_taken_mem[r_rd_ptr];
  assign w_sel_bh    = r_bh_mem[r_rd_ptr];
`endif

  // A bypassed entry goes straight to the BHT and never occupies a slot.
  assign w_push = in_valid & in_ready & ~flush & ~w_bypass;

  // If the previous write hit the same PC, the stored history is stale. Use
  // the history that write produced instead.
  assign w_repair     = r_last_valid && (r_last_pc == w_sel_pc);
  assign bh_ex        = w_repair ? r_last_hist : w_sel_bh;
  assign pc_update    = w_sel_pc;
  assign outcome_real = w_sel_taken;
  assign update_en    = w_pop | w_bypass;
  assign count        = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= in_pc;
      r_taken_mem[r_wr_ptr] <= in_taken;
      r_bh_mem[r_wr_ptr]    <= in_bh;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_last_valid <= 1'b0;
      r_last_pc    <= '0;
      r_last_hist  <= '0;
    end else begin
      // A write issued in a flush cycle is still committed, so it is recorded.
      if (update_en) begin
        r_last_valid <= 1'b1;
        r_last_pc    <= pc_update;
        r_last_hist  <= {bh_ex[bh_width-2:0], outcome_real};
      end
      if (flush) begin
        r_count  <= '0;
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
        if (w_push && !w_pop) begin
          r_count <= r_count + CntW'(1);
        end else if (!w_push && w_pop) begin
          r_count <= r_count - CntW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bht_update_queue.sv
module tb_bht_update_queue;

  localparam int unsigned AW = 30;
  localparam int unsigned BW = 14;
  localparam int unsigned D  = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_pc = '0;
  logic          in_taken = 1'b0;
  logic [BW-1:0] in_bh = '0;
  logic [AW-1:0] pc_update;
  logic          outcome_real;
  logic [BW-1:0] bh_ex;
  logic          update_en;
  logic [$clog2(D):0] count;

  bht_update_queue #(.ADDR_WIDTH(AW), .bh_width(BW), .DEPTH(D)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_taken(in_taken), .in_bh(in_bh), .pc_update(pc_update),
    .outcome_real(outcome_real), .bh_ex(bh_ex), .update_en(update_en),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of pending writes plus the last write.
  typedef struct {
    logic [AW-1:0] pc;
    logic          taken;
    logic [BW-1:0] bh;
  } ent_t;

  ent_t          mq[$];
  bit            m_last_valid = 1'b0;
  logic [AW-1:0] m_last_pc = '0;
  logic [BW-1:0] m_last_hist = '0;

  function automatic bit model_bypass();
    bit b = 1'b0;
`ifdef BHT_UPD_BYPASS_EN
    b = (mq.size() == 0) && in_valid && !stall && !flush;
`endif
    return b;
  endfunction

  function automatic ent_t model_head();
    ent_t e;
    if (model_bypass()) begin
      e.pc = in_pc; e.taken = in_taken; e.bh = in_bh;
    end else begin
      e = mq[0];
    end
    return e;
  endfunction

  function automatic logic [BW-1:0] model_hist(input ent_t e);
    return (m_last_valid && m_last_pc == e.pc) ? m_last_hist : e.bh;
  endfunction

  always @(posedge clk or negedge rstn) begin
    ent_t h;
    ent_t n;
    logic [BW-1:0] hb;
    bit byp;
    int sz;
    if (!rstn) begin
      mq.delete();
      m_last_valid = 1'b0;
    end else begin
      byp = model_bypass();
      sz  = mq.size();
      if ((sz != 0 && !stall) || byp) begin
        h  = model_head();
        hb = model_hist(h);
        m_last_valid = 1'b1;
        m_last_pc    = h.pc;
        m_last_hist  = {hb[BW-2:0], h.taken};
        if (!byp) void'(mq.pop_front());
      end
      if (flush) begin
        mq.delete();
      end else if (in_valid && sz != D && !byp) begin
        n.pc = in_pc; n.taken = in_taken; n.bh = in_bh;
        mq.push_back(n);
      end
    end
  end

  // Compare process, mid-cycle
  always @(negedge clk) begin
    ent_t h;
    bit   upd;
    if (rstn) begin
      upd = (mq.size() != 0 && !stall) || model_bypass();
      check("count", 64'(count), 64'(mq.size()));
      check("in_ready", 64'(in_ready), 64'(mq.size() != D));
      check("update_en", 64'(update_en), 64'(upd));
      if (upd) begin
        h = model_head();
        check("pc_update", 64'(pc_update), 64'(h.pc));
        check("outcome_real", 64'(outcome_real), 64'(h.taken));
        check("bh_ex", 64'(bh_ex), 64'(model_hist(h)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [AW-1:0] pc, input bit t,
                       input logic [BW-1:0] bh);
    in_valid = v; in_pc = pc; in_taken = t; in_bh = bh;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_update_en", 64'(update_en), 64'd0);

    // Single update
`ifdef BHT_UPD_BYPASS_EN
    drive(1, 30'h200, 1, 14'h0009);
    #1;
    check("byp_update_en", 64'(update_en), 64'd1);
    check("byp_pc", 64'(pc_update), 64'h200);
    tick();
    drive(0, '0, 0, '0);
    check("byp_count", 64'(count), 64'd0);
`endif
    drive(1, 30'h100, 1, 14'h0005);
    tick();
    drive(0, '0, 0, '0);
`ifndef BHT_UPD_BYPASS_EN
    check("single_update_en", 64'(update_en), 64'd1);
    check("single_pc", 64'(pc_update), 64'h100);
    check("single_bh", 64'(bh_ex), 64'h0005);
`endif
    tick();
    check("single_count", 64'(count), 64'd0);

    // Fill and stall
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 30'h10 + 30'(i), 1'(i), 14'(i + 20));
      tick();
    end
    drive(1, 30'h14, 1, 14'h3);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_count", 64'(count), 64'd4);
    tick();
    drive(0, '0, 0, '0);
    check("full_count_hold", 64'(count), 64'd4);
    stall = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("drain_en", 64'(update_en), 64'd1);
      check("drain_pc", 64'(pc_update), 64'h10 + 64'(i));
      tick();
    end
    check("drain_count", 64'(count), 64'd0);

    // Repair
    drive(1, 30'h40, 1, 14'h0001);
    tick();
    drive(1, 30'h40, 0, 14'h0001);
`ifndef BHT_UPD_BYPASS_EN
    check("repair_first_bh", 64'(bh_ex), 64'h0001);
`endif
    tick();
    drive(1, 30'h40, 1, 14'h0010);
`ifndef BHT_UPD_BYPASS_EN
    check("repair_second_bh", 64'(bh_ex), 64'h0003);
`endif
    tick();
    drive(1, 30'h80, 0, 14'h0022);
`ifndef BHT_UPD_BYPASS_EN
    check("repair_chain_bh", 64'(bh_ex), 64'h0006);
`endif
    tick();
    drive(1, 30'h40, 0, 14'h0007);
`ifndef BHT_UPD_BYPASS_EN
    check("other_pc_bh", 64'(bh_ex), 64'h0022);
`endif
    tick();
    drive(0, '0, 0, '0);
`ifndef BHT_UPD_BYPASS_EN
    check("own_bh_after_other", 64'(bh_ex), 64'h0007);
`endif
    tick();

    // Flush
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 30'h50 + 30'(i), 1, 14'(i));
      tick();
    end
    flush = 1'b1;
    drive(1, 30'h99, 1, 14'h1);
    tick();
    flush = 1'b0;
    drive(0, '0, 0, '0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_update_en", 64'(update_en), 64'd0);
    stall = 1'b0;
    tick();
    check("flush_lost", 64'(count), 64'd0);

    // Reset mid-drain
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1, 30'h60 + 30'(i), 0, 14'(i));
      tick();
    end
    drive(0, '0, 0, '0);
    stall = 1'b0;
    #1;
    check("pre_rst_update_en", 64'(update_en), 64'd1);
    check("pre_rst_count", 64'(count), 64'd2);
    #1 rstn = 1'b0;
    #1;
    check("mid_rst_update_en", 64'(update_en), 64'd0);
    tick();
    rstn = 1'b1;
    #1;
    check("post_rst_count", 64'(count), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [AW-1:0] pc;
      case ($urandom_range(3))
        0:       pc = 30'h40;
        1:       pc = 30'h41;
        2:       pc = 30'h80;
        default: pc = AW'($urandom);
      endcase
      drive($urandom_range(9) < 7, pc, 1'($urandom), BW'($urandom));
      stall = ($urandom_range(3) == 0);
      flush = ($urandom_range(19) == 0);
      tick();
    end
    drive(0, '0, 0, '0);
    stall = 1'b0;
    flush = 1'b0;
    repeat (D + 2) tick();
    check("final_count", 64'(count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bht_update_queue.md
# bht_update_queue

Buffers resolved conditional-branch outcomes from the execute stage and drains them, one per cycle, into the branch-history table's write port. It drives the BHT update-side signals (`pc_update`, `outcome_real`, `bh_ex`, `update_en`). It also repairs stale history when back-to-back updates target the same PC, so two in-flight branches that read the same history do not overwrite each other's shift.

## Interface

Parameters:

- `ADDR_WIDTH`, default 30: PC width (word address), matches the BHT.
- `bh_width`, default 14: branch-history width, matches the BHT.
- `DEPTH`, default 4: queue entries; power of two, at least 2.

Ports:

- `clk`  in  1  — single clock.
- `rstn`  in  1  — reset; asynchronous, active-low.
- `stall`  in  1  — BHT write port unavailable; hold the head entry.
- `flush`  in  1  — discard all queued, not-yet-written entries.
- `in_valid`  in  1  — resolved branch offered by EX.
- `in_ready`  out  1  — queue can accept this cycle.
- `in_pc`  in  ADDR_WIDTH  — PC of the resolved branch.
- `in_taken`  in  1  — real outcome.
- `in_bh`  in  bh_width  — history read at predict time.
- `pc_update`  out  ADDR_WIDTH  — to BHT update PC.
- `outcome_real`  out  1  — to BHT.
- `bh_ex`  out  bh_width  — history the BHT shifts; it writes `{bh_ex[bh_width-2:0], outcome_real}`.
- `update_en`  out  1  — BHT write enable.
- `count`  out  $clog2(DEPTH)+1  — occupied entries.

## Operation

- Circular FIFO with `rd_ptr`/`wr_ptr` of width $clog2(DEPTH) and a separate `count`. Pointers wrap modulo DEPTH.
- **Push** occurs when `in_valid & in_ready & ~flush`.
  - `in_ready = (count != DEPTH)`.
  - Full is decided on registered `count` only; no same-cycle pop credit.
- **Pop** occurs when `update_en`, where `update_en = (count != 0) & ~stall`.
- `pc_update` and `outcome_real` come from the head entry.
- **Last-write register**: `last_valid`, `last_pc`, `last_hist`.
  - On every pop: `last_pc <= pc_update`, `last_hist <= {bh_ex[bh_width-2:0], outcome_real}`, `last_valid <= 1`.
- **History repair**: `bh_ex = (last_valid && last_pc == head.pc) ? last_hist : head.bh`.
- Push and pop in the same cycle leave `count` unchanged.
- **Flush**:
  - Synchronous: at the next edge, `count <= 0` and `rd_ptr <= wr_ptr`.
  - A push presented in the flush cycle is dropped.
  - `update_en` in the flush cycle still fires; that write is architecturally committed.
  - The last-write register is retained across flush.
- **Stall**: `update_en = 0`; head, pointers and last-write register are held. Pushes continue while not full.
- **Reset**: `count = 0`, pointers 0, `last_valid = 0`, `update_en = 0`, `in_ready = 1`. Queue storage is not reset. `pc_update`, `outcome_real` and `bh_ex` are don't-care while `update_en = 0`.
- Reset asserted mid-operation discards all entries immediately (asynchronous).

## Timing

- Entry pushed at edge t has `update_en` high in cycle t+1 (earliest), if it is the head and `stall = 0`.
- Throughput: one update per cycle.
- `in_ready` and `update_en` are combinational from registered state plus `stall`. There is no combinational path from `in_*` to outputs (without the configuration macro).
- Repair compares against the write that completed at the previous pop edge. Two same-PC entries drained on consecutive cycles therefore chain correctly.

## Configuration

- `BHT_UPD_BYPASS_EN` defined:
  - When `count == 0`, `in_valid = 1`, `stall = 0` and `flush = 0`, the input is written through in the same cycle.
  - Outputs are driven straight from the input: `pc_update = in_pc`, `outcome_real = in_taken`, `bh_ex` repaired against the last-write register.
  - `update_en = 1`, no push occurs, and the last-write register updates at that edge.
  - Latency becomes 0 cycles.
- `BHT_UPD_BYPASS_EN` not defined: no bypass; minimum latency is 1 cycle, and outputs are registered-state only.

## Test plan

- **Single update**: reset, then push pc=0x100, taken=1, bh=0x0005 with stall=0.
  - Next cycle: `update_en=1`, `pc_update=0x100`, `bh_ex=0x0005`.
  - Following cycle: `count=0`.
- **Fill and stall**: stall=1, push 4 entries, then attempt a 5th.
  - `in_ready=0` and `count=4`; the 5th is not accepted.
  - Release stall: 4 consecutive `update_en` pulses in push order.
- **Repair**: push pc=0x40 bh=0x0001 taken=1, then pc=0x40 bh=0x0001 taken=0.
  - Second write shows `bh_ex=0x0003`, not 0x0001.
  - A different PC in between uses its own `bh`.
- **Flush**: 3 entries queued with stall=1; assert flush together with `in_valid`.
  - Next cycle: `count=0`, `update_en=0`; the incoming entry is lost.
- **Reset mid-drain**: drop `rstn` while `count=2` and `update_en=1`.
  - `update_en=0` immediately; after release, `count=0` and `in_ready=1`.
- **Bypass** (`BHT_UPD_BYPASS_EN` only): empty queue, push pc=0x200.
  - `update_en=1` in the same cycle; `count` stays 0.
